// File: rtl/md_mdp_parser_if.sv
// Byte-stream and request bus between the line receiver, the master message
// parser and the slave data packet controller.
interface md_mdp_parser_if;
  logic [7:0] rx_d;
  logic       rx_rdy;
  logic       rx_frame_err;
  logic       sd_s_req;
  logic       sd_d_req;
  logic       rx_err;
  logic [7:0] pl_d;
  logic       pl_rdy;
  logic       busy;

  // Line-receiver side: drives bytes, observes parser results.
  modport master (
    output rx_d, rx_rdy, rx_frame_err,
    input  sd_s_req, sd_d_req, rx_err, pl_d, pl_rdy, busy
  );

  // Parser side.
  modport slave (
    input  rx_d, rx_rdy, rx_frame_err,
    output sd_s_req, sd_d_req, rx_err, pl_d, pl_rdy, busy
  );
endinterface

// File: rtl/md_mdp_parser.sv
// Receive-side master message parser: validates marker / command / length /
// payload / checksum frames, forwards payload bytes and issues one request
// pulse per frame with a matching error level.
module md_mdp_parser #(
  parameter logic [7:0]  MARKER_MASTER  = 8'hA5,
  parameter logic [7:0]  CMD_SERVICE    = 8'h01,
  parameter logic [7:0]  CMD_DATA       = 8'h02,
  parameter int unsigned MAX_PL_LEN     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input logic            clk,
  input logic            n_rst,
  md_mdp_parser_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StN1, StN2, StPayload, StCsum, StSkip
  } state_e;

  state_e      state_q;
  logic [15:0] gap_q;
  logic [7:0]  sum_q;
  logic [7:0]  len_hi_q;
  logic [10:0] len_q;
  logic [10:0] pl_cnt_q;
  logic        cmd_data_q;
  logic [7:0]  pl_d_q;
  logic        pl_rdy_q;
  logic        s_req_q;
  logic        d_req_q;
  logic        rx_err_q;

  logic        byte_ev;
  logic        gap_exp;
  logic [15:0] len_w;
  logic [7:0]  sum_nx;

  // A frame error on the same strobe discards the byte.
  assign byte_ev = bus.rx_rdy & ~bus.rx_frame_err;
  assign gap_exp = (gap_q == 16'(TIMEOUT_CYCLES - 1));
  assign len_w   = {len_hi_q, bus.rx_d};
  assign sum_nx  = sum_q + bus.rx_d;

  // Frame FSM with gap timer, running checksum and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      gap_q      <= '0;
      sum_q      <= '0;
      len_hi_q   <= '0;
      len_q      <= '0;
      pl_cnt_q   <= '0;
      cmd_data_q <= 1'b0;
      pl_d_q     <= '0;
      pl_rdy_q   <= 1'b0;
      s_req_q    <= 1'b0;
      d_req_q    <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      pl_rdy_q <= 1'b0;
      s_req_q  <= 1'b0;
      d_req_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          gap_q <= '0;
          if (byte_ev && bus.rx_d == MARKER_MASTER) begin
            state_q <= StCmd;
            sum_q   <= '0;
          end
        end
        StSkip: begin
          // Every byte, marker included, keeps the discard window open.
          if (byte_ev) begin
            gap_q <= '0;
          end else if (gap_exp) begin
            state_q  <= StIdle;
            gap_q    <= '0;
            s_req_q  <= 1'b1;
            rx_err_q <= 1'b1;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        default: begin
          if (bus.rx_frame_err || (!byte_ev && gap_exp)) begin
            state_q <= StSkip;
            gap_q   <= '0;
          end else if (!byte_ev) begin
            gap_q <= gap_q + 16'd1;
          end else begin
            gap_q <= '0;
            case (state_q)
              StCmd: begin
                if (bus.rx_d == CMD_SERVICE || bus.rx_d == CMD_DATA) begin
                  cmd_data_q <= (bus.rx_d == CMD_DATA);
                  sum_q      <= sum_nx;
                  state_q    <= StN1;
                end else begin
                  state_q <= StSkip;
                end
              end
              StN1: begin
                len_hi_q <= bus.rx_d;
                sum_q    <= sum_nx;
                state_q  <= StN2;
              end
              StN2: begin
                sum_q    <= sum_nx;
                len_q    <= len_w[10:0];
                pl_cnt_q <= '0;
                if (len_w > 16'(MAX_PL_LEN)) begin
                  state_q <= StSkip;
                end else if (len_w == 16'd0) begin
                  state_q <= StCsum;
                end else begin
                  state_q <= StPayload;
                end
              end
              StPayload: begin
                pl_d_q   <= bus.rx_d;
                pl_rdy_q <= 1'b1;
                sum_q    <= sum_nx;
                if (pl_cnt_q == len_q - 11'd1) begin
                  state_q <= StCsum;
                end else begin
                  pl_cnt_q <= pl_cnt_q + 11'd1;
                end
              end
              StCsum: begin
                state_q  <= StIdle;
                rx_err_q <= (bus.rx_d != sum_q);
                if (bus.rx_d == sum_q && cmd_data_q) begin
                  d_req_q <= 1'b1;
                end else begin
                  s_req_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.sd_s_req = s_req_q;
  assign bus.sd_d_req = d_req_q;
  assign bus.rx_err   = rx_err_q;
  assign bus.pl_d     = pl_d_q;
  assign bus.pl_rdy   = pl_rdy_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_md_mdp_parser.sv
// Scoreboard bench for md_mdp_parser: frames are built as byte lists, the
// expected payload and request outcome are derived from the frame contents
// and queued; a monitor pops and compares whenever the DUT presents output.
module tb_md_mdp_parser;

  localparam longint T = 5000;

  typedef struct {
    bit     is_data;
    bit     err;
    longint at;
  } req_t;

  logic   clk;
  logic   n_rst;
  longint cyc;
  longint last_ev;
  int     n_vec;
  int     n_bad;

  logic [7:0] exp_pl[$];
  req_t       exp_req[$];

  req_t       mr;
  logic [7:0] mp;

  md_mdp_parser_if bus ();

  md_mdp_parser dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compare every output event against the scoreboard queues.
  always @(posedge clk) begin
    #1;
    if (bus.pl_rdy) begin
      if (exp_pl.size() == 0) begin
        chk("pl_unexpected", 1, 0);
      end else begin
        mp = exp_pl.pop_front();
        chk("pl_d", bus.pl_d, mp);
      end
    end
    if (bus.sd_s_req || bus.sd_d_req) begin
      chk("req_one_hot", bus.sd_s_req & bus.sd_d_req, 0);
      if (exp_req.size() == 0) begin
        chk("req_unexpected", 1, 0);
      end else begin
        mr = exp_req.pop_front();
        chk("req_kind_d", bus.sd_d_req, mr.is_data);
        chk("rx_err", bus.rx_err, mr.err);
        chk("req_cycle", cyc, mr.at);
      end
    end
  end

  // One stimulus cycle; a strobe is sampled at the following rising edge.
  task automatic drv(input logic rdy, input logic fe, input logic [7:0] d);
    @(negedge clk);
    bus.rx_rdy       = rdy;
    bus.rx_frame_err = fe;
    bus.rx_d         = d;
    if (rdy) last_ev = cyc + 1;
  endtask

  task automatic idle_noise(input int n);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom_range(0, 255));
      if (d == 8'hA5) d = 8'h5A;
      drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
    end
  endtask

  // Build a frame, derive its expected outcome, and drive it.
  // fe_idx: byte index replaced by a frame-error strobe (-1 none).
  // stall_idx: byte index before which the sender goes silent (-1 none).
  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] len, input bit ck_ok,
                            input int fe_idx, input int stall_idx, input int maxgap,
                            input bit fixed);
    logic [7:0] fr[$];
    logic [7:0] sum;
    logic [7:0] b;
    int         e;
    int         nj;
    req_t       r;
    fr.push_back(8'hA5);
    fr.push_back(cmd);
    fr.push_back(len[15:8]);
    fr.push_back(len[7:0]);
    sum = cmd + len[15:8] + len[7:0];
    if (len <= 16'd1024) begin
      for (int j = 0; j < int'(len); j++) begin
        b = fixed ? 8'(8'h11 * (j + 1)) : 8'($urandom_range(0, 255));
        fr.push_back(b);
        sum = sum + b;
      end
      fr.push_back(ck_ok ? sum : sum + 8'd1);
    end
    e = -1;
    if (cmd != 8'h01 && cmd != 8'h02) e = 1;
    else if (len > 16'd1024) e = 3;
    if (fe_idx > 0 && (e < 0 || fe_idx <= e)) e = fe_idx;
    for (int i = 0; i < fr.size(); i++) begin
      if (i == stall_idx) begin
        // Timeout mid-frame, then a full discard window.
        r = '{1'b0, 1'b1, last_ev + 2 * T};
        exp_req.push_back(r);
        repeat (2 * T + 2) drv(1'b0, 1'b0, 8'h00);
        return;
      end
      if (i > 0) repeat ($urandom_range(0, maxgap)) drv(1'b0, 1'b0, 8'h00);
      drv(1'b1, (i == fe_idx), fr[i]);
      if (i == 1) chk("busy_in_frame", bus.busy, 1);
      if (i >= 4 && i < fr.size() - 1 && (e < 0 || i < e)) exp_pl.push_back(fr[i]);
      if (e < 0 && i == fr.size() - 1) begin
        r = '{(cmd == 8'h02) && ck_ok, !ck_ok, last_ev};
        exp_req.push_back(r);
      end
      if (i == e) break;
    end
    if (e >= 0) begin
      // Trailing bytes, marker first, must all be swallowed.
      nj = $urandom_range(1, 4);
      for (int j = 0; j < nj; j++) begin
        repeat ($urandom_range(0, 3)) drv(1'b0, 1'b0, 8'h00);
        drv(1'b1, 1'b0, (j == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
      end
      r = '{1'b0, 1'b1, last_ev + T};
      exp_req.push_back(r);
      repeat (T + 2) drv(1'b0, 1'b0, 8'h00);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rc;
    logic [15:0] rl;
    int          rf;
    n_vec            = 0;
    n_bad            = 0;
    last_ev          = 0;
    n_rst            = 1'b0;
    bus.rx_d         = 8'h00;
    bus.rx_rdy       = 1'b0;
    bus.rx_frame_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_req", bus.sd_s_req, 0);
    chk("rst_d_req", bus.sd_d_req, 0);
    chk("rst_rx_err", bus.rx_err, 0);
    chk("rst_pl_rdy", bus.pl_rdy, 0);
    chk("rst_pl_d", bus.pl_d, 0);
    chk("rst_busy", bus.busy, 0);
    n_rst = 1'b1;
    idle_noise(6);

    // Valid service frame, checksum 01.
    send_frame(8'h01, 16'd0, 1'b1, -1, -1, 0, 1'b0);
    drv(1'b0, 1'b0, 8'h00);
    chk("busy_after_pulse", bus.busy, 0);
    chk("rx_err_service", bus.rx_err, 0);
    repeat (3) drv(1'b0, 1'b0, 8'h00);

    // Data frame 11 22 33, checksum 6B then 6C.
    send_frame(8'h02, 16'd3, 1'b1, -1, -1, 0, 1'b1);
    repeat (2) drv(1'b0, 1'b0, 8'h00);
    send_frame(8'h02, 16'd3, 1'b0, -1, -1, 1, 1'b1);
    repeat (2) drv(1'b0, 1'b0, 8'h00);

    // Bad command, over-length, frame error on second payload byte.
    send_frame(8'h07, 16'd2, 1'b1, -1, -1, 0, 1'b0);
    send_frame(8'h01, 16'h0401, 1'b1, -1, -1, 0, 1'b0);
    send_frame(8'h02, 16'd4, 1'b1, 5, -1, 1, 1'b0);
    send_frame(8'h01, 16'd0, 1'b1, -1, -1, 0, 1'b0);
    drv(1'b0, 1'b0, 8'h00);

    // Longest legal payload, sent back-to-back into a short frame.
    send_frame(8'h02, 16'd1024, 1'b1, -1, -1, 0, 1'b0);
    send_frame(8'h02, 16'd1, 1'b1, -1, -1, 0, 1'b0);
    drv(1'b0, 1'b0, 8'h00);

    // Stall mid-payload.
    send_frame(8'h02, 16'd4, 1'b1, -1, 6, 0, 1'b0);

    // Reset in the middle of a frame: no pulse, outputs cleared.
    drv(1'b1, 1'b0, 8'hA5);
    drv(1'b1, 1'b0, 8'h02);
    drv(1'b1, 1'b0, 8'h00);
    drv(1'b1, 1'b0, 8'h04);
    drv(1'b1, 1'b0, 8'h3C);
    exp_pl.push_back(8'h3C);
    drv(1'b1, 1'b0, 8'hC3);
    exp_pl.push_back(8'hC3);
    @(negedge clk);
    bus.rx_rdy = 1'b0;
    n_rst      = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rx_err", bus.rx_err, 0);
    chk("mid_rst_pl_rdy", bus.pl_rdy, 0);
    chk("mid_rst_pl_d", bus.pl_d, 0);
    chk("mid_rst_s_req", bus.sd_s_req, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (4) drv(1'b0, 1'b0, 8'h00);
    send_frame(8'h02, 16'd3, 1'b1, -1, -1, 0, 1'b0);
    drv(1'b0, 1'b0, 8'h00);

    // Randomized frames with line noise between them.
    for (int k = 0; k < 24; k++) begin
      rc = ($urandom_range(0, 1) != 0) ? 8'h02 : 8'h01;
      if (k % 8 == 3) rc = 8'h07 + 8'($urandom_range(0, 100));
      rl = 16'($urandom_range(0, 6));
      rf = (k % 8 == 5) ? int'($urandom_range(1, 4 + int'(rl))) : -1;
      send_frame(rc, rl, $urandom_range(0, 3) != 0, rf, -1, 2, 1'b0);
      idle_noise($urandom_range(0, 3));
    end

    repeat (10) drv(1'b0, 1'b0, 8'h00);
    chk("pl_queue_empty", exp_pl.size(), 0);
    chk("req_queue_empty", exp_req.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/md_mdp_parser.md
Name: md_mdp_parser

Overview:
- Receive-side master message parser. Sits directly upstream of the slave data packet controller.
- Consumes deserialized bytes from the line receiver and validates master frames: marker, command, 16-bit length, payload, checksum.
- Issues exactly one request pulse per frame, sd_s_req or sd_d_req, with a matching rx_err level. Payload bytes are forwarded to the slave data path.

Parameters:
- MARKER_MASTER, 8'hA5, required first byte of every master frame.
- CMD_SERVICE, 8'h01, command code for a service request.
- CMD_DATA, 8'h02, command code for a data request.
- MAX_PL_LEN, 1024, largest legal payload length in bytes (fits 11 bits).
- TIMEOUT_CYCLES, 5000, inter-byte gap that aborts or ends a frame (16-bit counter).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; asynchronous, active-low.
- rx_d  in  8  received byte; valid when rx_rdy=1.
- rx_rdy  in  1  one-cycle strobe, byte available.
- rx_frame_err  in  1  one-cycle strobe, line-level framing/parity error on current byte.
- sd_s_req  out  1  one-cycle pulse: service reply required.
- sd_d_req  out  1  one-cycle pulse: data reply required.
- rx_err  out  1  level: error flag for the last completed frame; valid on the request pulse cycle and held until the next pulse.
- pl_d  out  8  forwarded payload byte.
- pl_rdy  out  1  one-cycle strobe, pl_d valid.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and checksum 0. Reset mid-frame aborts silently, with no request pulse.
- A byte event is rx_rdy=1 with rx_frame_err=0. If rx_rdy and rx_frame_err are high together, the frame error wins and the byte is discarded.
- Checksum: 8-bit running sum, mod 256, of command, N1, N2 and all payload bytes. The marker is excluded.
- States and transitions:
  - IDLE: byte == MARKER_MASTER -> CMD. Any other byte is ignored. rx_frame_err is ignored. No timeout in IDLE.
  - CMD: byte is CMD_SERVICE or CMD_DATA -> latch cmd, go to N1. Any other value -> err_lat=1, go to SKIP.
  - N1: latch length[15:8] -> N2.
  - N2: latch length[7:0]. If length > MAX_PL_LEN -> err_lat=1, go to SKIP. If length == 0 -> CSUM. Otherwise -> PAYLOAD with pl_cnt=0.
  - PAYLOAD: each byte -> pl_d=byte and pl_rdy=1 on the next cycle; pl_cnt increments. After the byte where pl_cnt reaches length-1 -> CSUM.
  - CSUM: byte == running sum -> err_lat=0, otherwise err_lat=1. Go to IDLE and issue the request pulse.
  - SKIP: discard all bytes, including the marker. When the gap timer expires -> IDLE and pulse sd_s_req with rx_err=1.
- Error sources in CMD, N1, N2, PAYLOAD and CSUM, all going to SKIP with err_lat=1:
  - rx_frame_err;
  - gap timer expiry, which starts the SKIP gap count afresh.
- Gap timer:
  - Clears on every byte event and on state entry.
  - Counts clk cycles in non-IDLE states.
  - Expires when the count == TIMEOUT_CYCLES-1.
- Request pulse:
  - Issued in the cycle after the CSUM byte event, or after SKIP expiry.
  - Exactly one of sd_s_req or sd_d_req is asserted.
  - A valid CMD_DATA frame -> sd_d_req. A valid CMD_SERVICE frame, or any error -> sd_s_req.
  - rx_err is updated from err_lat in the same cycle as the pulse.
- Payload integrity: payload bytes are forwarded before the checksum is known. The consumer discards buffered payload when rx_err=1 on the closing pulse.
- busy deasserts in the cycle the request pulse is issued.
- Back-to-back frames: a marker byte arriving in the cycle immediately after the CSUM byte is accepted in IDLE.

Test Plan:
- Valid service frame A5 01 00 00 01 (checksum 01) -> single sd_s_req pulse one cycle after the last byte; rx_err=0; no pl_rdy; busy low afterwards.
- Valid data frame A5 02 00 03 11 22 33 with checksum 02+00+03+11+22+33 = 0x6B -> three pl_rdy pulses carrying 11, 22, 33; then sd_d_req with rx_err=0.
- Same data frame with checksum 0x6C -> three pl_rdy pulses, then sd_s_req with rx_err=1; sd_d_req never asserted.
- Bad command A5 07 ... followed by continuous bytes, then a 5000-cycle gap -> no pl_rdy; sd_s_req with rx_err=1 exactly TIMEOUT_CYCLES cycles after the last byte; a marker inside the skipped stream is ignored.
- Length 0x0401 (>1024), and separately rx_frame_err on the second payload byte -> SKIP; after the gap, sd_s_req with rx_err=1. Then a following valid service frame -> rx_err returns to 0.
- Stall of 5000 cycles mid-payload, then n_rst asserted mid-frame on a second frame -> first frame: sd_s_req with rx_err=1. Reset: immediate outputs 0, state IDLE, no pulse. A fresh valid frame after reset parses correctly.
